// File: rtl/pack_can.sv
// Frame packer: sends up to three identifier-led groups of tagged 12-bit payloads
// as 16-bit words, each framed by a setup/strobe/gap cs cycle.
module pack_can #(
   parameter int ID1     = 513,
   parameter int ID2     = 514,
   parameter int ID3     = 515,
   parameter int T_SETUP = 2,
   parameter int T_HIGH  = 4,
   parameter int T_GAP   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  grp_en,
   input  logic [11:0] data1,
   input  logic [11:0] data2,
   input  logic [11:0] data3,
   input  logic [11:0] data4,
   input  logic [11:0] data5,
   input  logic [11:0] data6,
   input  logic [11:0] data7,
   output logic [15:0] word_out,
   output logic        cs,
   output logic        busy,
   output logic        done
);

   localparam int T_MAX = (T_SETUP > T_HIGH) ? ((T_SETUP > T_GAP) ? T_SETUP : T_GAP)
                                             : ((T_HIGH  > T_GAP) ? T_HIGH  : T_GAP);
   localparam int PW = $clog2(T_MAX + 1);

   localparam logic [PW-1:0] SETUP_LAST  = PW'(T_SETUP - 1);
   localparam logic [PW-1:0] HIGH_LAST   = PW'(T_HIGH - 1);
   localparam logic [PW-1:0] GAP_LAST    = PW'(T_GAP - 1);
   localparam logic [PW-1:0] PHASE_ONE   = PW'(1);
   localparam logic [3:0]    IDX_END     = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_GAP,
      S_DONE
   } state_t;

   // data1 lives in element 0, data7 in element 6
   typedef logic [6:0][11:0] payload_t;

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [3:0]    idx_q, idx_d;
   logic [15:0]   word_q, word_d;
   payload_t      data_q, data_d;
   logic [2:0]    en_q, en_d;

   payload_t      snap;
   logic [3:0]    first_idx;
   logic [3:0]    idx_nxt;

   // Word positions: 0 = ID1, 1..3 = group 1 data, 4 = ID2, 5..7 = group 2 data,
   // 8 = ID3, 9 = group 3 data. Index 10 means "no more words".
   function automatic logic [15:0] word_at(input logic [3:0] idx, input payload_t p);
      logic [15:0] w;
      case (idx)
         4'd0:    w = 16'(ID1);
         4'd1:    w = {2'b00, 2'd1, p[0]};
         4'd2:    w = {2'b00, 2'd2, p[1]};
         4'd3:    w = {2'b00, 2'd3, p[2]};
         4'd4:    w = 16'(ID2);
         4'd5:    w = {2'b00, 2'd1, p[3]};
         4'd6:    w = {2'b00, 2'd2, p[4]};
         4'd7:    w = {2'b00, 2'd3, p[5]};
         4'd8:    w = 16'(ID3);
         4'd9:    w = {2'b00, 2'd1, p[6]};
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

   // Landing on a disabled group's identifier jumps over the whole group.
   function automatic logic [3:0] skip_disabled(input logic [3:0] idx, input logic [2:0] en);
      logic [3:0] r;
      r = idx;
      if (r == 4'd0 && !en[0]) r = 4'd4;
      if (r == 4'd4 && !en[1]) r = 4'd8;
      if (r == 4'd8 && !en[2]) r = IDX_END;
      return r;
   endfunction

   assign snap      = {data7, data6, data5, data4, data3, data2, data1};
   assign first_idx = skip_disabled(4'd0, grp_en);
   assign idx_nxt   = skip_disabled(idx_q + 4'd1, en_q);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         data_q  <= '0;
         en_q    <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         data_q  <= data_d;
         en_q    <= en_d;
      end
   end

   // NOTE: every variable gets a hold default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      word_d  = word_q;
      data_d  = data_q;
      en_d    = en_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               data_d  = snap;
               en_d    = grp_en;
               phase_d = '0;
               idx_d   = first_idx;
               if (grp_en == 3'b000) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SETUP;
                  word_d  = word_at(first_idx, snap);
               end
            end
         end
         S_SETUP: begin
            if (phase_q == SETUP_LAST) begin
               phase_d = '0;
               state_d = S_STROBE;
            end else begin
               phase_d = phase_q + PHASE_ONE;
            end
         end
         S_STROBE: begin
            if (phase_q == HIGH_LAST) begin
               phase_d = '0;
               state_d = S_GAP;
            end else begin
               phase_d = phase_q + PHASE_ONE;
            end
         end
         S_GAP: begin
            if (phase_q == GAP_LAST) begin
               phase_d = '0;
               if (idx_nxt == IDX_END) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SETUP;
                  idx_d   = idx_nxt;
                  word_d  = word_at(idx_nxt, data_q);
               end
            end else begin
               phase_d = phase_q + PHASE_ONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes decode straight from state so reset drops cs without waiting for a clock.
   always_comb begin
      cs   = (state_q == S_STROBE);
      busy = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_GAP);
      done = (state_q == S_DONE);
   end

   assign word_out = word_q;

endmodule

// File: tb/tb_pack_can.sv
// Directed bench for pack_can: frame timing, group skipping, start/data isolation,
// mid-frame reset and a receiver model decoding the cs-strobed words.
module tb_pack_can;

   typedef logic [6:0][11:0] pay_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  grp_en = 3'b000;
   logic [11:0] data1 = '0, data2 = '0, data3 = '0, data4 = '0;
   logic [11:0] data5 = '0, data6 = '0, data7 = '0;
   logic [15:0] word_out;
   logic        cs, busy, done;

   pack_can dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .grp_en   (grp_en),
      .data1    (data1),
      .data2    (data2),
      .data3    (data3),
      .data4    (data4),
      .data5    (data5),
      .data6    (data6),
      .data7    (data7),
      .word_out (word_out),
      .cs       (cs),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Receiver-side monitor, sampled on the falling edge.
   logic [15:0] words[$];
   logic [15:0] exp_q[$];
   int          done_cnt, done_cyc, busy_seen, stab_err, rx_grp;
   logic        prev_cs = 1'b0;
   logic [15:0] prev_word = '0;
   logic [11:0] rx [7];

   task automatic rx_word(input logic [15:0] w);
      int k;
      if (w[13:12] == 2'd0) begin
         rx_grp = (w == 16'h0201) ? 0 : (w == 16'h0202) ? 1 : (w == 16'h0203) ? 2 : -1;
      end else if (rx_grp >= 0) begin
         k = rx_grp * 3 + int'(w[13:12]) - 1;
         if (k < 7) rx[k] = w[11:0];
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cs && !prev_cs) begin
            words.push_back(word_out);
            rx_word(word_out);
            if (word_out != prev_word) stab_err++;
         end
         if (cs && prev_cs && word_out != prev_word) stab_err++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy) busy_seen++;
         prev_cs   = cs;
         prev_word = word_out;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_mon();
      words.delete();
      done_cnt  = 0;
      done_cyc  = -1;
      busy_seen = 0;
      stab_err  = 0;
      rx_grp    = -1;
      for (int i = 0; i < 7; i++) rx[i] = 12'hEEE;
   endtask

   int t0;

   task automatic start_frame(input logic [2:0] en, input pay_t d);
      clear_mon();
      grp_en = en;
      {data7, data6, data5, data4, data3, data2, data1} = d;
      t0    = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      check("done_seen", (done_cnt != 0) ? 1 : 0, 1);
   endtask

   function automatic void build_exp(input logic [2:0] en, input pay_t d);
      int n;
      exp_q.delete();
      for (int g = 0; g < 3; g++) begin
         if (en[g]) begin
            exp_q.push_back(16'h0201 + 16'(g));
            n = (g == 2) ? 1 : 3;
            for (int t = 1; t <= n; t++)
               exp_q.push_back({2'b00, 2'(t), d[g*3 + t - 1]});
         end
      end
   endfunction

   task automatic compare_words(input string tag);
      check({tag, "_nwords"}, words.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_word%0d", tag, i), (i < words.size()) ? words[i] : 16'hDEAD, exp_q[i]);
      check({tag, "_stable"}, stab_err, 0);
   endtask

   pay_t d_seq, d_loop;

   initial begin
      d_seq  = {12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1};
      d_loop = {12'hABC, 12'h789, 12'h456, 12'h123, 12'h000, 12'h800, 12'hFFF};
      clear_mon();

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_word", word_out, 16'h0000);
      check("rst_cs", cs, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst_n = 1'b1;
      tick();
      tick();

      // Full frame timing and sequence
      start_frame(3'b111, d_seq);
      check("full_w_t1", word_out, 16'h0201);
      check("full_busy_t1", busy, 1'b1);
      check("full_cs_t1", cs, 1'b0);
      tick();
      check("full_cs_t2", cs, 1'b0);
      tick();
      check("full_cs_t3", cs, 1'b1);
      repeat (3) tick();
      check("full_cs_t6", cs, 1'b1);
      tick();
      check("full_cs_t7", cs, 1'b0);
      wait_done(200);
      check("full_done_cyc", done_cyc, t0 + 81);
      exp_q = '{16'h0201, 16'h1001, 16'h2002, 16'h3003, 16'h0202,
                16'h1004, 16'h2005, 16'h3006, 16'h0203, 16'h1007};
      compare_words("full");
      check("full_done_cnt", done_cnt, 1);
      check("full_hold_word", word_out, 16'h1007);
      check("full_busy_after", busy, 1'b0);

      // Group 3 only
      tick();
      start_frame(3'b100, {12'd175, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0});
      wait_done(100);
      check("g3_done_cyc", done_cyc, t0 + 17);
      exp_q = '{16'h0203, 16'h10AF};
      compare_words("g3");

      // Empty mask
      tick();
      start_frame(3'b000, d_seq);
      wait_done(20);
      check("empty_done_cyc", done_cyc, t0 + 1);
      check("empty_nwords", words.size(), 0);
      check("empty_busy", busy_seen, 0);
      check("empty_done_cnt", done_cnt, 1);

      // Restart and data change during word 3 must not disturb the frame
      tick();
      start_frame(3'b111, d_seq);
      repeat (17) tick();
      start  = 1'b1;
      data1  = 12'h555;
      grp_en = 3'b001;
      tick();
      start = 1'b0;
      wait_done(200);
      check("restart_done_cyc", done_cyc, t0 + 81);
      repeat (12) tick();
      build_exp(3'b111, d_seq);
      compare_words("restart");
      check("restart_done_cnt", done_cnt, 1);
      check("restart_rx_d1", rx[0], 12'd1);

      // Reset during STROBE of word 5
      start_frame(3'b111, d_seq);
      repeat (35) tick();
      check("abort_pre_cs", cs, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_cs", cs, 1'b0);
      check("abort_word", word_out, 16'h0000);
      check("abort_busy", busy, 1'b0);
      repeat (3) tick();
      check("abort_no_done", done_cnt, 0);
      rst_n = 1'b1;
      repeat (4) tick();
      check("abort_idle_busy", busy, 1'b0);
      start_frame(3'b111, d_seq);
      check("abort_new_w1", word_out, 16'h0201);
      wait_done(200);
      check("abort_new_done_cyc", done_cyc, t0 + 81);
      build_exp(3'b111, d_seq);
      compare_words("after_abort");

      // Loopback into the receiver model
      tick();
      start_frame(3'b111, d_loop);
      wait_done(200);
      for (int i = 0; i < 7; i++)
         check($sformatf("loop_rx%0d", i + 1), rx[i], d_loop[i]);
      build_exp(3'b111, d_loop);
      compare_words("loop");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
